// File: rtl/pixel_packer.sv
// Packs a byte stream into 3-byte (RGB) or 4-byte (RGBW) pixels tagged with EOF/PAD,
// hands them to the LED FIFO under backpressure, and keeps per-frame pixel statistics.
module pixel_packer #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENABLE,
  input  logic [7:0]       FORMAT,
  input  logic             BYTE_VALID,
  input  logic [7:0]       BYTE_DATA,
  input  logic             BYTE_LAST,
  output logic             BYTE_READY,
  input  logic             FIFO_FULL,
  output logic             FIFO_WE,
  output logic [33:0]      FIFO_WDATA,
  input  logic             CLR_ERR,
  output logic             PARTIAL_ERR,
  output logic             FRAME_DONE,
  output logic [CNT_W-1:0] PIXEL_COUNT,
  output logic [CNT_W-1:0] LAST_FRAME_PIXELS
);

  typedef enum logic {
    ACCUM,
    WRITE
  } state_t;

  state_t      state;
  logic [1:0]  idx;
  logic [1:0]  fmt_lat;
  logic [1:0]  fmt_cur;
  logic [1:0]  last_idx;
  logic [1:0]  lane;
  logic [31:0] acc;
  logic [31:0] acc_next;
  logic        accept;
  logic        done_pix;
  logic        pad;
  logic        unused_fmt;

  assign unused_fmt = ^FORMAT[7:2];

  assign BYTE_READY = !RST && ENABLE && (state == ACCUM);
  assign FIFO_WE    = !RST && ENABLE && (state == WRITE) && !FIFO_FULL;
  assign accept     = BYTE_VALID && BYTE_READY;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // The format in force for the byte at index 0 is the live input; later bytes
  // of the same pixel use the copy latched when index 0 was accepted.
  always_comb begin
    fmt_cur  = (idx == 2'd0) ? FORMAT[1:0] : fmt_lat;
    last_idx = fmt_cur[0] ? 2'd3 : 2'd2;
    lane     = fmt_cur[1] ? idx : (last_idx - idx);
    acc_next = (idx == 2'd0) ? '0 : acc;
    acc_next[{lane, 3'b000} +: 8] = BYTE_DATA;
    done_pix = (idx == last_idx) || BYTE_LAST;
    pad      = (idx != last_idx);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state             <= ACCUM;
      idx               <= '0;
      fmt_lat           <= '0;
      acc               <= '0;
      FIFO_WDATA        <= '0;
      PARTIAL_ERR       <= 1'b0;
      FRAME_DONE        <= 1'b0;
      PIXEL_COUNT       <= '0;
      LAST_FRAME_PIXELS <= '0;
    end else begin
      FRAME_DONE <= 1'b0;
      if (CLR_ERR) begin
        PARTIAL_ERR <= 1'b0;
      end
      if (!ENABLE) begin
        state       <= ACCUM;
        idx         <= '0;
        PIXEL_COUNT <= '0;
      end else begin
        case (state)
          ACCUM: begin
            if (accept) begin
              if (idx == 2'd0) begin
                fmt_lat <= FORMAT[1:0];
              end
              acc <= acc_next;
              if (done_pix) begin
                FIFO_WDATA <= {BYTE_LAST, pad, acc_next};
                // A partial pixel sets the flag after any clear above, so set wins.
                if (pad) begin
                  PARTIAL_ERR <= 1'b1;
                end
                state <= WRITE;
                idx   <= '0;
              end else begin
                idx <= idx + 2'd1;
              end
            end
          end
          WRITE: begin
            if (!FIFO_FULL) begin
              state <= ACCUM;
              if (FIFO_WDATA[33]) begin
                LAST_FRAME_PIXELS <= sat_inc(PIXEL_COUNT);
                PIXEL_COUNT       <= '0;
                FRAME_DONE        <= 1'b1;
              end else begin
                PIXEL_COUNT <= sat_inc(PIXEL_COUNT);
              end
            end
          end
          default: state <= ACCUM;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pixel_packer.sv
// Directed bench for pixel_packer: a table of single-pixel vectors followed by
// hand-written backpressure, error-flag, enable-drop and long-frame sequences.
module tb_pixel_packer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ENABLE;
  logic [7:0]  FORMAT;
  logic        BYTE_VALID;
  logic [7:0]  BYTE_DATA;
  logic        BYTE_LAST;
  logic        BYTE_READY;
  logic        FIFO_FULL;
  logic        FIFO_WE;
  logic [33:0] FIFO_WDATA;
  logic        CLR_ERR;
  logic        PARTIAL_ERR;
  logic        FRAME_DONE;
  logic [15:0] PIXEL_COUNT;
  logic [15:0] LAST_FRAME_PIXELS;

  int n_chk = 0;
  int n_fail = 0;
  int we_count = 0;
  int eof_count = 0;
  logic last_eof = 1'b0;

  pixel_packer #(.CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .FORMAT(FORMAT),
    .BYTE_VALID(BYTE_VALID), .BYTE_DATA(BYTE_DATA), .BYTE_LAST(BYTE_LAST),
    .BYTE_READY(BYTE_READY), .FIFO_FULL(FIFO_FULL), .FIFO_WE(FIFO_WE),
    .FIFO_WDATA(FIFO_WDATA), .CLR_ERR(CLR_ERR), .PARTIAL_ERR(PARTIAL_ERR),
    .FRAME_DONE(FRAME_DONE), .PIXEL_COUNT(PIXEL_COUNT),
    .LAST_FRAME_PIXELS(LAST_FRAME_PIXELS)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (FIFO_WE) begin
      we_count++;
      if (FIFO_WDATA[33]) eof_count++;
      last_eof = FIFO_WDATA[33];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  fmt;
    int unsigned n;
    logic [31:0] bytes;
    logic        last;
    logic [33:0] wdata;
    logic [15:0] cnt;
    logic        fd;
    logic [15:0] lfp;
    logic        perr;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Offers n bytes (first byte in bits 31:24), waiting a bounded time for each handshake.
  task automatic send(input logic [31:0] bytes, input int unsigned n, input logic last);
    logic ok;
    for (int unsigned i = 0; i < n; i++) begin
      BYTE_VALID = 1'b1;
      BYTE_DATA  = bytes[31 - 8*i -: 8];
      BYTE_LAST  = last && (i == n - 1);
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
        @(negedge CLK);
        ok = BYTE_READY;
        @(posedge CLK);
        #1;
      end
      chk("byte_accept", {63'd0, ok}, 64'd1);
    end
    BYTE_VALID = 1'b0;
    BYTE_LAST  = 1'b0;
  endtask

  initial begin
    int wc0;
    int ec0;
    logic [7:0] pb;

    vecs[0] = '{8'h00, 3, 32'h11223300, 1'b1, 34'h2_00112233, 16'd0, 1'b1, 16'd1, 1'b0};
    vecs[1] = '{8'h03, 4, 32'hAABBCCDD, 1'b0, 34'h0_DDCCBBAA, 16'd1, 1'b0, 16'd1, 1'b0};
    vecs[2] = '{8'hFC, 3, 32'hA1B2C300, 1'b0, 34'h0_00A1B2C3, 16'd2, 1'b0, 16'd1, 1'b0};
    vecs[3] = '{8'h01, 4, 32'h01020304, 1'b1, 34'h2_01020304, 16'd0, 1'b1, 16'd3, 1'b0};
    vecs[4] = '{8'h02, 3, 32'h10203000, 1'b0, 34'h0_00302010, 16'd1, 1'b0, 16'd3, 1'b0};
    vecs[5] = '{8'h00, 2, 32'h01020000, 1'b1, 34'h3_00010200, 16'd0, 1'b1, 16'd2, 1'b1};
    vecs[6] = '{8'h03, 1, 32'h5A000000, 1'b1, 34'h3_0000005A, 16'd0, 1'b1, 16'd1, 1'b1};

    RST = 1'b1; ENABLE = 1'b1; FORMAT = 8'h00; BYTE_VALID = 1'b0; BYTE_DATA = 8'h00;
    BYTE_LAST = 1'b0; FIFO_FULL = 1'b0; CLR_ERR = 1'b0;
    repeat (3) step();
    chk("rst_ready", {63'd0, BYTE_READY}, 64'd0);
    chk("rst_we", {63'd0, FIFO_WE}, 64'd0);
    chk("rst_wdata", {30'd0, FIFO_WDATA}, 64'd0);
    chk("rst_perr", {63'd0, PARTIAL_ERR}, 64'd0);
    chk("rst_fd", {63'd0, FRAME_DONE}, 64'd0);
    chk("rst_cnt", {48'd0, PIXEL_COUNT}, 64'd0);
    chk("rst_lfp", {48'd0, LAST_FRAME_PIXELS}, 64'd0);
    RST = 1'b0;
    #1;
    chk("ready_after_rst", {63'd0, BYTE_READY}, 64'd1);

    for (int i = 0; i < 7; i++) begin
      FORMAT = vecs[i].fmt;
      send(vecs[i].bytes, vecs[i].n, vecs[i].last);
      chk($sformatf("v%0d_we", i), {63'd0, FIFO_WE}, 64'd1);
      chk($sformatf("v%0d_wdata", i), {30'd0, FIFO_WDATA}, {30'd0, vecs[i].wdata});
      step();
      chk($sformatf("v%0d_we_done", i), {63'd0, FIFO_WE}, 64'd0);
      chk($sformatf("v%0d_fd", i), {63'd0, FRAME_DONE}, {63'd0, vecs[i].fd});
      chk($sformatf("v%0d_cnt", i), {48'd0, PIXEL_COUNT}, {48'd0, vecs[i].cnt});
      chk($sformatf("v%0d_lfp", i), {48'd0, LAST_FRAME_PIXELS}, {48'd0, vecs[i].lfp});
      chk($sformatf("v%0d_perr", i), {63'd0, PARTIAL_ERR}, {63'd0, vecs[i].perr});
      step();
      chk($sformatf("v%0d_fd_pulse", i), {63'd0, FRAME_DONE}, 64'd0);
    end

    // CLR_ERR alone clears the sticky flag.
    CLR_ERR = 1'b1;
    step();
    CLR_ERR = 1'b0;
    chk("clr_alone", {63'd0, PARTIAL_ERR}, 64'd0);

    // Clear coinciding with a new partial EOF: set wins.
    FORMAT = 8'h00;
    send(32'h01000000, 1, 1'b0);
    BYTE_VALID = 1'b1; BYTE_DATA = 8'h02; BYTE_LAST = 1'b1; CLR_ERR = 1'b1;
    step();
    BYTE_VALID = 1'b0; BYTE_LAST = 1'b0; CLR_ERR = 1'b0;
    chk("set_wins_perr", {63'd0, PARTIAL_ERR}, 64'd1);
    chk("set_wins_we", {63'd0, FIFO_WE}, 64'd1);
    chk("set_wins_wdata", {30'd0, FIFO_WDATA}, {30'd0, 34'h3_00010200});
    step();

    // Backpressure held for 5 cycles from pixel completion.
    wc0 = we_count;
    FIFO_FULL = 1'b1;
    send(32'h11223300, 3, 1'b0);
    BYTE_VALID = 1'b1; BYTE_DATA = 8'h77;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d_we", c), {63'd0, FIFO_WE}, 64'd0);
      chk($sformatf("bp%0d_ready", c), {63'd0, BYTE_READY}, 64'd0);
      chk($sformatf("bp%0d_wdata", c), {30'd0, FIFO_WDATA}, {30'd0, 34'h0_00112233});
      step();
    end
    FIFO_FULL = 1'b0; BYTE_VALID = 1'b0;
    #1;
    chk("bp_release_we", {63'd0, FIFO_WE}, 64'd1);
    step();
    chk("bp_after_we", {63'd0, FIFO_WE}, 64'd0);
    chk("bp_cnt", {48'd0, PIXEL_COUNT}, 64'd1);
    chk("bp_writes", wc0 + 0, 64'(we_count - 1));

    // ENABLE dropped at index 2 discards the partial pixel.
    FORMAT = 8'h00;
    send(32'h44550000, 2, 1'b0);
    ENABLE = 1'b0;
    #1;
    chk("en_low_ready", {63'd0, BYTE_READY}, 64'd0);
    step();
    ENABLE = 1'b1;
    chk("en_low_cnt", {48'd0, PIXEL_COUNT}, 64'd0);
    send(32'h77889900, 3, 1'b0);
    chk("en_resume_we", {63'd0, FIFO_WE}, 64'd1);
    chk("en_resume_wdata", {30'd0, FIFO_WDATA}, {30'd0, 34'h0_00778899});
    step();
    chk("en_resume_cnt", {48'd0, PIXEL_COUNT}, 64'd1);

    // ENABLE dropped while a word waits in WRITE discards it.
    FIFO_FULL = 1'b1;
    send(32'h12345600, 3, 1'b0);
    wc0 = we_count;
    ENABLE = 1'b0; FIFO_FULL = 1'b0;
    #1;
    chk("en_write_we", {63'd0, FIFO_WE}, 64'd0);
    step();
    ENABLE = 1'b1;
    #1;
    chk("en_write_we_after", {63'd0, FIFO_WE}, 64'd0);
    chk("en_write_ready", {63'd0, BYTE_READY}, 64'd1);
    chk("en_write_cnt", {48'd0, PIXEL_COUNT}, 64'd0);
    chk("en_keep_lfp", {48'd0, LAST_FRAME_PIXELS}, 64'd1);
    chk("en_keep_perr", {63'd0, PARTIAL_ERR}, 64'd1);
    step();
    step();
    chk("en_write_discarded", 64'(we_count), 64'(wc0));
    CLR_ERR = 1'b1;
    step();
    CLR_ERR = 1'b0;
    chk("final_clr", {63'd0, PARTIAL_ERR}, 64'd0);

    // 300-pixel frame with a mid-pixel FORMAT change on pixel 150.
    wc0 = we_count;
    ec0 = eof_count;
    FORMAT = 8'h00;
    for (int p = 0; p < 300; p++) begin
      pb = p[7:0];
      if (p == 150) begin
        send({pb, 8'hA5, 8'h5A, 8'h00}, 1, 1'b0);
        FORMAT = 8'h03;
        send({8'hA5, 8'h5A, 16'h0000}, 2, 1'b0);
        chk("fmt_change_we", {63'd0, FIFO_WE}, 64'd1);
        chk("fmt_change_wdata", {30'd0, FIFO_WDATA}, {30'd0, 34'h0_0096A55A});
        FORMAT = 8'h00;
      end else begin
        send({pb, 8'hA5, 8'h5A, 8'h00}, 3, p == 299);
      end
    end
    repeat (3) step();
    chk("long_writes", 64'(we_count - wc0), 64'd300);
    chk("long_eofs", 64'(eof_count - ec0), 64'd1);
    chk("long_last_eof", {63'd0, last_eof}, 64'd1);
    chk("long_lfp", {48'd0, LAST_FRAME_PIXELS}, 64'h012C);
    chk("long_cnt", {48'd0, PIXEL_COUNT}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_packer.md
# pixel_packer

Byte-to-pixel assembly stage that sits directly upstream of the LED FIFO and feeds it. It accepts the pixel byte stream extracted from SPI writes by the controller and packs 3-byte (RGB) or 4-byte (RGBW) pixels into 34-bit FIFO words. Each word carries end-of-frame and padding tags. It honours FIFO backpressure and reports per-frame pixel counts and malformed-frame errors to the register block.

## Interface

Parameters:
- CNT_W, 16, width of the pixel counters.

Ports:
- CLK  in  1  system clock (on-chip oscillator); one clock, all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- ENABLE  in  1  block enable; low = flush and idle.
- FORMAT  in  8  bit0: 0 = 3 bytes/pixel, 1 = 4 bytes/pixel; bit1: 0 = first byte to MSB, 1 = first byte to LSB; bits 7:2 ignored.
- BYTE_VALID  in  1  byte offered.
- BYTE_DATA  in  8  byte value.
- BYTE_LAST  in  1  qualifies BYTE_VALID; byte is the last of the frame.
- BYTE_READY  out  1  byte accepted when BYTE_VALID & BYTE_READY.
- FIFO_FULL  in  1  LED FIFO full.
- FIFO_WE  out  1  FIFO write strobe.
- FIFO_WDATA  out  34  [33] EOF, [32] PAD, [31:0] pixel data.
- CLR_ERR  in  1  clears PARTIAL_ERR.
- PARTIAL_ERR  out  1  sticky; a frame ended mid-pixel.
- FRAME_DONE  out  1  one-cycle pulse when an EOF word is written.
- PIXEL_COUNT  out  CNT_W  pixels written in the current frame.
- LAST_FRAME_PIXELS  out  CNT_W  pixel count of the last completed frame.

## Operation

- States:
  - ACCUM: BYTE_READY = ENABLE.
  - WRITE: BYTE_READY = 0; word held in the output register.
- Byte index (0..N-1, N = 3 or 4) starts at 0.
- FORMAT[1:0] is latched when byte index 0 is accepted. Changes mid-pixel take effect on the next pixel.
- Byte placement:
  - MSB-first: byte k goes to bits [8*(N-1-k)+7 : 8*(N-1-k)].
  - LSB-first: byte k goes to bits [8k+7 : 8k].
  - 3-byte mode: data[31:24] = 0.
- Accepting byte N-1 forms the word, sets EOF = BYTE_LAST and PAD = 0, then moves to WRITE.
- Accepting BYTE_LAST with index < N-1:
  - Unreceived byte lanes are zero.
  - EOF = 1, PAD = 1; PARTIAL_ERR set; moves to WRITE.
- WRITE: FIFO_WE = !FIFO_FULL (combinational from state). When FIFO_WE = 1, return to ACCUM next cycle with index 0.
- FIFO_WDATA is stable throughout WRITE. It holds its last value otherwise and is valid only with FIFO_WE.
- Counters:
  - Each FIFO_WE increments PIXEL_COUNT, saturating at all-ones.
  - On an EOF write: LAST_FRAME_PIXELS ← PIXEL_COUNT+1 (saturated), PIXEL_COUNT ← 0, and FRAME_DONE pulses in the following cycle.
- ENABLE low (synchronous):
  - State → ACCUM, index → 0; a word pending in WRITE is discarded.
  - FIFO_WE = 0, BYTE_READY = 0, PIXEL_COUNT → 0.
  - PARTIAL_ERR and LAST_FRAME_PIXELS are retained.
- PARTIAL_ERR is set only by a partial EOF and cleared by CLR_ERR or RST. If set and clear coincide, set wins.
- Priority: RST > ENABLE low > normal operation.

## Timing

- Reset values: state ACCUM, index 0, BYTE_READY 0 in the reset cycle, FIFO_WE 0, FIFO_WDATA 0, PARTIAL_ERR 0, FRAME_DONE 0, PIXEL_COUNT 0, LAST_FRAME_PIXELS 0.
- BYTE_READY goes to 1 the cycle after RST deasserts if ENABLE = 1.
- Latency: completing byte accepted at cycle t → FIFO_WE at t+1 if FIFO_FULL = 0. Otherwise FIFO_WE in the first cycle with FIFO_FULL = 0.
- Peak throughput: one pixel per N+1 cycles.
- FIFO_FULL is sampled in the same cycle as FIFO_WE. No write is ever issued while FIFO_FULL = 1.
- FRAME_DONE is high for exactly one cycle, at t+1 after the EOF write cycle t. LAST_FRAME_PIXELS updates in that same cycle.

## Test plan

- 3-byte, MSB-first, FIFO empty: bytes 11, 22, 33 with LAST on 33 → single FIFO_WE one cycle after 33 accepted, FIFO_WDATA = 34'h2_00112233, FRAME_DONE pulse, LAST_FRAME_PIXELS = 1, PIXEL_COUNT = 0.
- 4-byte, LSB-first: bytes AA, BB, CC, DD, no LAST → FIFO_WDATA = 34'h0_DDCCBBAA, PIXEL_COUNT = 1, no FRAME_DONE.
- Backpressure: FIFO_FULL held high for 5 cycles from pixel completion → FIFO_WE stays 0, BYTE_READY stays 0, FIFO_WDATA stays stable; exactly one FIFO_WE on the cycle FIFO_FULL drops.
- Partial frame, 3-byte MSB-first: bytes 01, 02 with LAST on 02 → FIFO_WDATA = 34'h3_00010200, PARTIAL_ERR = 1.
  - CLR_ERR alone → PARTIAL_ERR = 0.
  - CLR_ERR coinciding with a new partial EOF → PARTIAL_ERR = 1.
- ENABLE dropped for 1 cycle after bytes 44, 55 (index 2), then bytes 77, 88, 99 → no write for 44/55; FIFO_WDATA = 34'h0_00778899. ENABLE dropped while in WRITE → no FIFO_WE for the discarded word.
- 300 back-to-back 3-byte pixels with LAST on the final byte → 300 FIFO_WE pulses, only the last with bit33 = 1; LAST_FRAME_PIXELS = 16'h012C; a FORMAT change mid-pixel does not alter that pixel's packing.
